ifetch_queue: RTL and testbench

- Instruction-fetch prefetch stage directly upstream of the single-cycle core; supplies `Ins` for the core's current `PC`.
- Issues sequential word fetches to a variable-latency instruction memory over a req/ack handshake and buffers them in a small FIFO.
- Detects PC redirects (branch/jump) by address mismatch, then flushes and refetches.
- Core stalls (clock-enable gating, outside this block) while `InsValid`=0.

---
 rtl/ifetch_queue_if.sv | 29 ++
 rtl/ifetch_queue.sv | 147 ++++++++++++++
 tb/tb_ifetch_queue.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundles the core-side fetch signals and the instruction
// memory req/ack bus of ifetch_queue.
//   master : the fetch queue (drives Ins/InsValid and the memory request)
//   slave  : the environment (core + instruction memory)
// Signals:
//   PC, Advance          core program counter / consume strobe
//   Ins, InsValid        instruction for PC and its validity
//   imem_req, imem_addr  fetch request and word address
//   imem_ack, imem_rdata completion strobe and fetched instruction
interface ifetch_queue_if;
  logic [31:0] PC;
  logic        Advance;
  logic [31:0] Ins;
  logic        InsValid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    input  PC, Advance, imem_ack, imem_rdata,
    output Ins, InsValid, imem_req, imem_addr
  );

  modport slave (
    output PC, Advance, imem_ack, imem_rdata,
    input  Ins, InsValid, imem_req, imem_addr
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch stage. Issues sequential word fetches to
// a variable-latency instruction memory, buffers {addr, data} pairs in a
// DEPTH-entry FIFO and presents the head entry to the core when its address
// matches PC. A PC that does not match the expected address is a redirect:
// the FIFO is flushed and fetching restarts at PC; an in-flight request is
// completed and its data dropped.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    ifetch_queue_if.master (core side + imem req/ack bus)
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [31:0]    fetch_addr_q, fetch_addr_d;
  logic [31:0]    imem_addr_q, imem_addr_d;

  logic [31:0]    fifo_addr_q [DEPTH];
  logic [31:0]    fifo_data_q [DEPTH];

  logic           push;
  logic           pop;
  logic           ins_valid;
  logic           redirect;
  logic [31:0]    head_addr;
  logic [31:0]    expected_addr;
  logic [31:0]    next_fetch;

  assign head_addr  = fifo_addr_q[head_q];
  assign ins_valid  = (count_q != '0) && (head_addr == bus.PC);
  assign pop        = bus.Advance && ins_valid;
  assign next_fetch = fetch_addr_q + 32'd4;

  // Address the core should be asking for if no branch/jump happened.
  always_comb begin
    if (count_q != '0)          expected_addr = head_addr;
    else if (state_q == S_WAIT) expected_addr = imem_addr_q;
    else                        expected_addr = fetch_addr_q;
  end

  assign redirect = (bus.PC != expected_addr) && !pop;

  assign bus.InsValid  = ins_valid;
  assign bus.Ins       = ins_valid ? fifo_data_q[head_q] : NOP;
  assign bus.imem_req  = (state_q != S_IDLE);
  assign bus.imem_addr = imem_addr_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    fetch_addr_d = fetch_addr_q;
    imem_addr_d  = imem_addr_q;
    push         = 1'b0;

    if (pop) begin
      head_d  = head_q + PW'(1);
      count_d = count_q - CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_addr_d = bus.PC;
          count_d      = '0;
          head_d       = tail_q;
        end else if (count_q < CW'(DEPTH)) begin
          state_d     = S_WAIT;
          imem_addr_d = fetch_addr_q;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          // The outstanding request must still complete; its data is stale.
          fetch_addr_d = bus.PC;
          count_d      = '0;
          head_d       = tail_q;
          state_d      = bus.imem_ack ? S_IDLE : S_DISCARD;
        end else if (bus.imem_ack) begin
          push         = 1'b1;
          tail_d       = tail_q + PW'(1);
          count_d      = count_q + CW'(1) - CW'(pop);
          fetch_addr_d = next_fetch;
          // Only keep requesting while the post-push FIFO still has room,
          // so a push can never land on a full FIFO.
          if (count_d < CW'(DEPTH)) imem_addr_d = next_fetch;
          else                      state_d     = S_IDLE;
        end
      end

      S_DISCARD: begin
        if (redirect)     fetch_addr_d = bus.PC;
        if (bus.imem_ack) state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      fetch_addr_q <= RESET_PC;
      imem_addr_q  <= RESET_PC;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      fetch_addr_q <= fetch_addr_d;
      imem_addr_q  <= imem_addr_d;
    end
  end

  // Entry storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= imem_addr_q;
      fifo_data_q[tail_q] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ifetch_queue_if bus ();

  ifetch_queue #(
    .DEPTH    (4),
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: upper half tags the word, lower half is the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus.imem_rdata = mem(bus.imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic        adv;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ins;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, check combinational outputs,
  // then let one rising edge pass and return at the next falling edge.
  // imem_addr is only meaningful while a request is up.
  task automatic step(input string name, input logic [31:0] pc, input logic adv,
                      input logic ack, input logic exp_req, input logic [31:0] exp_addr,
                      input logic exp_valid, input logic [31:0] exp_ins);
    bus.PC       = pc;
    bus.Advance  = adv;
    bus.imem_ack = ack;
    #1;
    chk({name, ".req"},   {31'd0, bus.imem_req}, {31'd0, exp_req});
    if (exp_req) chk({name, ".addr"}, bus.imem_addr, exp_addr);
    chk({name, ".valid"}, {31'd0, bus.InsValid}, {31'd0, exp_valid});
    chk({name, ".ins"},   bus.Ins, exp_ins);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    reset        = 1'b0;
    bus.PC       = '0;
    bus.Advance  = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    chk({name, ".rst_req"},   {31'd0, bus.imem_req}, 32'd0);
    chk({name, ".rst_addr"},  bus.imem_addr, RESET_PC);
    chk({name, ".rst_valid"}, {31'd0, bus.InsValid}, 32'd0);
    chk({name, ".rst_ins"},   bus.Ins, NOP);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    bus.PC       = '0;
    bus.Advance  = 1'b0;
    bus.imem_ack = 1'b0;

    // Streaming, then fill to DEPTH with Advance low, one pop, refill.
    //          pc            adv   ack   req   addr          valid ins
    tbl[0]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, NOP};
    tbl[1]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, NOP};
    tbl[2]  = '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h4,        1'b1, 32'hC0DE_0000};
    tbl[3]  = '{32'h0000_0004, 1'b1, 1'b1, 1'b1, 32'h8,        1'b1, 32'hC0DE_0004};
    tbl[4]  = '{32'h0000_0008, 1'b1, 1'b1, 1'b1, 32'hC,        1'b1, 32'hC0DE_0008};
    tbl[5]  = '{32'h0000_000C, 1'b0, 1'b1, 1'b1, 32'h10,       1'b1, 32'hC0DE_000C};
    tbl[6]  = '{32'h0000_000C, 1'b0, 1'b1, 1'b1, 32'h14,       1'b1, 32'hC0DE_000C};
    tbl[7]  = '{32'h0000_000C, 1'b0, 1'b1, 1'b1, 32'h18,       1'b1, 32'hC0DE_000C};
    tbl[8]  = '{32'h0000_000C, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hC0DE_000C};
    tbl[9]  = '{32'h0000_000C, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC0DE_000C};
    tbl[10] = '{32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC0DE_0010};
    tbl[11] = '{32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'h1C,       1'b1, 32'hC0DE_0010};
    tbl[12] = '{32'h0000_0010, 1'b0, 1'b1, 1'b1, 32'h1C,       1'b1, 32'hC0DE_0010};
    tbl[13] = '{32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC0DE_0010};

    @(negedge clk);
    do_reset("A");
    for (int i = 0; i < 14; i++)
      step($sformatf("A%0d", i), tbl[i].pc, tbl[i].adv, tbl[i].ack,
           tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_valid, tbl[i].exp_ins);

    // Three-cycle memory; jump 0x8 -> 0x100 while 0xC is outstanding.
    do_reset("B");
    step("B0",  32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, NOP);
    step("B1",  32'h0,   1'b0, 1'b0, 1'b1, 32'h0,   1'b0, NOP);
    step("B2",  32'h0,   1'b0, 1'b0, 1'b1, 32'h0,   1'b0, NOP);
    step("B3",  32'h0,   1'b0, 1'b1, 1'b1, 32'h0,   1'b0, NOP);
    step("B4",  32'h0,   1'b1, 1'b0, 1'b1, 32'h4,   1'b1, 32'hC0DE_0000);
    step("B5",  32'h4,   1'b0, 1'b0, 1'b1, 32'h4,   1'b0, NOP);
    step("B6",  32'h4,   1'b0, 1'b0, 1'b1, 32'h4,   1'b0, NOP);
    step("B7",  32'h4,   1'b0, 1'b1, 1'b1, 32'h4,   1'b0, NOP);
    step("B8",  32'h4,   1'b1, 1'b0, 1'b1, 32'h8,   1'b1, 32'hC0DE_0004);
    step("B9",  32'h8,   1'b0, 1'b0, 1'b1, 32'h8,   1'b0, NOP);
    step("B10", 32'h8,   1'b0, 1'b0, 1'b1, 32'h8,   1'b0, NOP);
    step("B11", 32'h8,   1'b0, 1'b1, 1'b1, 32'h8,   1'b0, NOP);
    step("B12", 32'h8,   1'b1, 1'b0, 1'b1, 32'hC,   1'b1, 32'hC0DE_0008);
    step("B13", 32'h100, 1'b0, 1'b0, 1'b1, 32'hC,   1'b0, NOP);
    step("B14", 32'h100, 1'b0, 1'b0, 1'b1, 32'hC,   1'b0, NOP);
    step("B15", 32'h100, 1'b0, 1'b1, 1'b1, 32'hC,   1'b0, NOP);
    step("B16", 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, NOP);
    step("B17", 32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, NOP);
    step("B18", 32'h100, 1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'hC0DE_0100);

    // Redirect and ack in the same WAIT cycle.
    do_reset("C");
    step("C0", 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, NOP);
    step("C1", 32'h40, 1'b0, 1'b1, 1'b1, 32'h0,  1'b0, NOP);
    step("C2", 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, NOP);
    step("C3", 32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, NOP);
    step("C4", 32'h40, 1'b0, 1'b0, 1'b1, 32'h44, 1'b1, 32'hC0DE_0040);

    // Fetch address wraps past the top of the address space.
    do_reset("D");
    step("D0", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, NOP);
    step("D1", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, NOP);
    step("D2", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC,  1'b0, NOP);
    step("D3", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'h0,          1'b1, 32'hC0DE_FFFC);
    step("D4", 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,          1'b0, NOP);
    step("D5", 32'h0,         1'b0, 1'b0, 1'b1, 32'h4,          1'b1, 32'hC0DE_0000);

    // Asynchronous reset while a request is outstanding, late ack after.
    do_reset("E");
    step("E0", 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, NOP);
    step("E1", 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, NOP);
    step("E2", 32'h200, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, NOP);
    bus.imem_ack = 1'b1;
    #1;
    chk("E.pre_req", {31'd0, bus.imem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("E.async_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("E.async_addr",  bus.imem_addr, RESET_PC);
    chk("E.async_valid", {31'd0, bus.InsValid}, 32'd0);
    chk("E.async_ins",   bus.Ins, NOP);
    @(negedge clk);
    reset = 1'b1;
    step("E3", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, NOP);
    step("E4", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, NOP);
    step("E5", 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, NOP);
    step("E6", 32'h0, 1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 32'hC0DE_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
